// File: rtl/otter_intr_ctrl_if.sv
// otter_intr_ctrl_if: IOBUS register-access bundle between the MCU bus and the interrupt controller
interface otter_intr_ctrl_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rdata;
    logic        hit;
    modport master (output addr, wdata, wr, input rdata, hit);
    modport slave  (input addr, wdata, wr, output rdata, hit);
endinterface

// File: rtl/otter_intr_ctrl.sv
// otter_intr_ctrl: prioritised interrupt controller with assert/claim/complete sequencing over IOBUS
module otter_intr_ctrl #(
    parameter int          NUM_SRC   = 8,
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_SRC-1:0] i_src,
    output logic               o_intr,
    otter_intr_ctrl_if.slave   io_bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, INSVC = 2'd2} state_t;
    state_t             r_state, w_next;
    logic [NUM_SRC-1:0] r_s1, r_s2, r_s3, r_pend, r_en, r_mode;
    logic [NUM_SRC-1:0] w_elig, w_sel, w_rise, w_clr, w_m2l, w_pend_next, w_wd;
    logic [4:0]         r_id, w_best;
    logic               r_intr;
    logic [31:0]        w_off;
    logic [2:0]         w_word;
    logic               w_wr, w_wr_pend, w_wr_en, w_wr_mode, w_wr_claim, w_wr_cmpl;
    logic               w_claim, w_done, w_unused;

    // An address below the base wraps to a huge offset, so one compare covers both bounds
    assign w_off        = io_bus.addr - BASE_ADDR;
    assign w_word       = w_off[4:2];
    assign io_bus.hit   = w_off < 32'h14;
    assign w_wr         = io_bus.wr && io_bus.hit;
    assign w_wd         = io_bus.wdata[NUM_SRC-1:0];
    assign w_wr_pend    = w_wr && w_word == 3'd0;
    assign w_wr_en      = w_wr && w_word == 3'd1;
    assign w_wr_mode    = w_wr && w_word == 3'd2;
    assign w_wr_claim   = w_wr && w_word == 3'd3;
    assign w_wr_cmpl    = w_wr && w_word == 3'd4;
    assign w_unused     = ^{io_bus.wdata, w_off};
    assign w_elig       = r_pend & r_en;
    assign w_claim      = w_wr_claim && r_state == ASSERT && |w_elig;
    assign w_done       = w_wr_cmpl && r_state == INSVC && io_bus.wdata[4:0] == r_id;
    assign w_rise       = r_s2 & ~r_s3;
    assign w_clr        = (w_claim ? w_sel : '0) | (w_wr_pend ? w_wd : '0);
    assign w_m2l        = w_wr_mode ? (r_mode & ~w_wd) : '0;
    assign w_pend_next  = ((r_mode & (w_rise | (r_pend & ~w_clr))) | (~r_mode & r_s2)) & ~w_m2l;
    assign o_intr       = r_intr;
    assign io_bus.rdata = !io_bus.hit    ? 32'd0 :
                          w_word == 3'd0 ? 32'(r_pend) :
                          w_word == 3'd1 ? 32'(r_en) :
                          w_word == 3'd2 ? 32'(r_mode) :
                          w_word == 3'd3 ? {27'd0, w_best} :
                                           {22'd0, r_state, 3'd0, r_id};

    // Lowest eligible index wins; scanning high-to-low lets the last hit be the winner
    always_comb begin
        w_best = '0;
        w_sel  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_best = 5'(i + 1);
                w_sel  = '0;
                w_sel[i] = 1'b1;
            end
        end
    end

    // Synchronisers, pending/enable/mode registers and the claimed ID
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_s3   <= '0;
            r_pend <= '0;
            r_en   <= '0;
            r_mode <= '0;
            r_id   <= '0;
        end else begin
            r_s1   <= i_src;
            r_s2   <= r_s1;
            r_s3   <= r_s2;
            r_pend <= w_pend_next;
            if (w_wr_en) r_en <= w_wd;
            if (w_wr_mode) r_mode <= w_wd;
            if (w_claim) r_id <= w_best;
        end
    end

    // Service FSM state and registered INTR
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_intr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_intr  <= w_next == ASSERT;
        end
    end

    // Next-state: signal while eligible, hold off further requests until the claimed ID completes
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |w_elig ? ASSERT : IDLE;
            ASSERT:  w_next = w_claim ? INSVC : (|w_elig ? ASSERT : IDLE);
            INSVC:   w_next = w_done ? IDLE : INSVC;
            default: w_next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_otter_intr_ctrl.sv
// tb_otter_intr_ctrl: directed self-checking bench for the interrupt controller
module tb_otter_intr_ctrl;
    localparam logic [31:0] BASE = 32'h1100_0100;
    localparam logic [31:0] A_PEND = BASE, A_EN = BASE + 32'h4, A_MODE = BASE + 32'h8;
    localparam logic [31:0] A_CLAIM = BASE + 32'hC, A_CMPL = BASE + 32'h10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] src;
    logic       intr;
    logic [31:0] d;
    int tests = 0;
    int fails = 0;

    otter_intr_ctrl_if bus();

    otter_intr_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_src(src), .o_intr(intr), .io_bus(bus)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; the write lands on the next rising edge, returns at the following falling edge
    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        bus.addr = a; bus.wdata = v; bus.wr = 1'b1;
        @(negedge clk);
        bus.wr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus.addr = a;
        #1 v = bus.rdata;
    endtask

    task automatic pulse(input logic [7:0] m);
        src = m;
        @(negedge clk);
        src = '0;
    endtask

    task automatic test_reset;
        wr(A_MODE, 32'h01); wr(A_EN, 32'h01);
        pulse(8'h01);
        repeat (3) @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL reset_pre_intr got %0b want 1", intr); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL reset_intr_async got %0b want 0", intr); end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        rd(A_PEND, d);  tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_pend got %h want 0", d); end
        rd(A_EN, d);    tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_en got %h want 0", d); end
        rd(A_MODE, d);  tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_mode got %h want 0", d); end
        rd(A_CLAIM, d); tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_claim got %h want 0", d); end
        rd(A_CMPL, d);  tests++; if (d !== 32'h0) begin fails++; $display("FAIL reset_cmpl got %h want 0", d); end
        @(negedge clk);
    endtask

    task automatic test_edge;
        wr(A_MODE, 32'hFF); wr(A_EN, 32'h01);
        pulse(8'h01);
        @(negedge clk);
        rd(A_PEND, d); tests++; if (d !== 32'h0) begin fails++; $display("FAIL edge_pend_early got %h want 0", d); end
        @(negedge clk);
        rd(A_PEND, d); tests++; if (d !== 32'h1) begin fails++; $display("FAIL edge_pend got %h want 1", d); end
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL edge_intr_early got %0b want 0", intr); end
        @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL edge_intr got %0b want 1", intr); end
        rd(A_CLAIM, d); tests++; if (d !== 32'h1) begin fails++; $display("FAIL edge_claim_id got %h want 1", d); end
        wr(A_CLAIM, 32'h0);
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL edge_intr_claimed got %0b want 0", intr); end
        rd(A_PEND, d); tests++; if (d !== 32'h0) begin fails++; $display("FAIL edge_pend_claimed got %h want 0", d); end
        rd(A_CMPL, d); tests++; if (d !== 32'h201) begin fails++; $display("FAIL edge_insvc got %h want 201", d); end
        wr(A_CMPL, 32'h1);
        rd(A_CMPL, d); tests++; if (d !== 32'h001) begin fails++; $display("FAIL edge_idle got %h want 001", d); end
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL edge_intr_done got %0b want 0", intr); end
    endtask

    task automatic test_priority;
        wr(A_EN, 32'h24);
        pulse(8'h24);
        repeat (3) @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL prio_intr got %0b want 1", intr); end
        rd(A_CLAIM, d); tests++; if (d !== 32'h3) begin fails++; $display("FAIL prio_claim got %h want 3", d); end
        wr(A_CLAIM, 32'h0);
        rd(A_PEND, d); tests++; if (d !== 32'h20) begin fails++; $display("FAIL prio_pend got %h want 20", d); end
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL prio_insvc_intr got %0b want 0", intr); end
        wr(A_CMPL, 32'h3);
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL prio_gap got %0b want 0", intr); end
        @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL prio_reassert got %0b want 1", intr); end
        rd(A_CLAIM, d); tests++; if (d !== 32'h6) begin fails++; $display("FAIL prio_claim2 got %h want 6", d); end
        wr(A_CLAIM, 32'h0); wr(A_CMPL, 32'h6);
        rd(A_CMPL, d); tests++; if (d !== 32'h006) begin fails++; $display("FAIL prio_idle got %h want 006", d); end
    endtask

    task automatic test_level;
        wr(A_MODE, 32'h00); wr(A_EN, 32'h10);
        src = 8'h10;
        repeat (4) @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL lvl_intr got %0b want 1", intr); end
        rd(A_CLAIM, d); tests++; if (d !== 32'h5) begin fails++; $display("FAIL lvl_claim got %h want 5", d); end
        wr(A_CLAIM, 32'h0);
        rd(A_PEND, d); tests++; if (d !== 32'h10) begin fails++; $display("FAIL lvl_pend_kept got %h want 10", d); end
        wr(A_CMPL, 32'h5);
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL lvl_gap got %0b want 0", intr); end
        @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL lvl_reassert got %0b want 1", intr); end
        src = 8'h00;
        repeat (4) @(negedge clk);
        tests++; if (intr !== 1'b0) begin fails++; $display("FAIL lvl_drop_intr got %0b want 0", intr); end
        rd(A_CMPL, d); tests++; if (d[9:8] !== 2'd0) begin fails++; $display("FAIL lvl_drop_state got %0d want 0", d[9:8]); end
    endtask

    task automatic test_back_to_back;
        wr(A_MODE, 32'hFF); wr(A_EN, 32'h03);
        pulse(8'h01);
        repeat (3) @(negedge clk);
        wr(A_CLAIM, 32'h0);
        wr(A_CMPL, 32'h2);
        rd(A_CMPL, d); tests++; if (d !== 32'h201) begin fails++; $display("FAIL mism_stay got %h want 201", d); end
        wr(A_CMPL, 32'h1);
        pulse(8'h01);
        repeat (3) @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL coll_intr got %0b want 1", intr); end
        pulse(8'h01);
        @(negedge clk);
        wr(A_CLAIM, 32'h0);
        rd(A_PEND, d); tests++; if (d !== 32'h1) begin fails++; $display("FAIL coll_pend got %h want 1", d); end
        rd(A_CMPL, d); tests++; if (d !== 32'h201) begin fails++; $display("FAIL coll_insvc got %h want 201", d); end
        wr(A_CMPL, 32'h1);
        @(negedge clk);
        tests++; if (intr !== 1'b1) begin fails++; $display("FAIL coll_reassert got %0b want 1", intr); end
        wr(A_CLAIM, 32'h0); wr(A_CMPL, 32'h1);
    endtask

    task automatic test_decode;
        wr(A_EN, 32'hFFFF_FFFF);
        rd(A_EN, d); tests++; if (d !== 32'hFF) begin fails++; $display("FAIL dec_width got %h want ff", d); end
        wr(A_EN, 32'h5A);
        rd(BASE + 32'h5, d); tests++; if (d !== 32'h5A) begin fails++; $display("FAIL dec_alias got %h want 5a", d); end
        rd(BASE, d);           tests++; if (bus.hit !== 1'b1) begin fails++; $display("FAIL dec_hit_lo got %0b want 1", bus.hit); end
        rd(BASE + 32'h13, d);  tests++; if (bus.hit !== 1'b1) begin fails++; $display("FAIL dec_hit_hi got %0b want 1", bus.hit); end
        rd(BASE - 32'h1, d);   tests++; if (bus.hit !== 1'b0 || d !== 32'h0) begin fails++; $display("FAIL dec_below got hit=%0b rd=%h want 0/0", bus.hit, d); end
        rd(BASE + 32'h14, d);  tests++; if (bus.hit !== 1'b0 || d !== 32'h0) begin fails++; $display("FAIL dec_above got hit=%0b rd=%h want 0/0", bus.hit, d); end
        wr(BASE + 32'h14, 32'hFF);
        rd(A_EN, d);   tests++; if (d !== 32'h5A) begin fails++; $display("FAIL dec_nowrite_en got %h want 5a", d); end
        rd(A_MODE, d); tests++; if (d !== 32'hFF) begin fails++; $display("FAIL dec_nowrite_mode got %h want ff", d); end
    endtask

    initial begin
        rst_n = 1'b0; src = '0;
        bus.addr = '0; bus.wdata = '0; bus.wr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset;
        test_edge;
        test_priority;
        test_level;
        test_back_to_back;
        test_decode;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
